// File: rtl/signed_bcd_module_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : signed_bcd_module_pkg
//  Purpose  : Shared constants for the signed binary-to-BCD converter:
//             data/BCD widths, iteration count and FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package signed_bcd_module_pkg;

   localparam int DATA_W   = 8;    // binary input width
   localparam int BCD_W    = 12;   // hundreds/tens/units
   localparam int ITER_CNT = 8;    // one double-dabble step per input bit
   localparam int CNT_W    = 3;
   localparam int STATE_W  = 3;

   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_LOAD  = 3'd1;
   localparam logic [STATE_W-1:0] ST_SHIFT = 3'd2;
   localparam logic [STATE_W-1:0] ST_OUT   = 3'd3;
   localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/signed_bcd_module_bin2bcd_step.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_step
//  Purpose  : One combinational double-dabble step: add 3 to every BCD digit
//             that is >= 5, then shift the accumulator left one bit, taking
//             the next binary bit into the LSB.
//  Ports    : bcd_in  [11:0] accumulator before the step
//             bin_msb        next magnitude bit (MSB first)
//             bcd_out [11:0] accumulator after the step
//  Revision : 1.0  initial release
// ============================================================================
module bin2bcd_step
   import signed_bcd_module_pkg::*;
(
   input  logic [BCD_W-1:0] bcd_in,
   input  logic             bin_msb,
   output logic [BCD_W-1:0] bcd_out
);

   logic [BCD_W-1:0] w_adj;

   for (genvar d = 0; d < BCD_W/4; d++) begin : g_digit
      assign w_adj[4*d +: 4] = (bcd_in[4*d +: 4] >= 4'd5) ?
                               (bcd_in[4*d +: 4] + 4'd3) : bcd_in[4*d +: 4];
   end

   // The top bit of the hundreds digit is discarded; magnitudes never exceed
   // 255, so the hundreds digit stays below 8 and nothing is lost.
   assign bcd_out = {w_adj[BCD_W-2:0], bin_msb};

endmodule
`default_nettype wire

// File: rtl/signed_bcd_module.sv
`default_nettype none
// ============================================================================
//  Module   : signed_bcd_module
//  Purpose  : Converts a divider's quotient and remainder to sign + 3-digit
//             BCD magnitude using 8 sequential double-dabble steps.
//             Define SIGNED_BCD_SIGNED_EN for two's-complement inputs;
//             otherwise inputs are unsigned 0..255 and signs read 0.
//  Ports    : clk, rst (sync, active high), start_sig (level, advances FSM)
//             quotient[7:0], reminder[7:0]    divider results
//             done_sig                        one-cycle result-valid pulse
//             q_sign, q_bcd[11:0]             quotient sign / BCD magnitude
//             r_sign, r_bcd[11:0]             remainder sign / BCD magnitude
//  Revision : 1.0  initial release
// ============================================================================
module signed_bcd_module
   import signed_bcd_module_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start_sig,
   input  logic [DATA_W-1:0] quotient,
   input  logic [DATA_W-1:0] reminder,
   output logic              done_sig,
   output logic              q_sign,
   output logic [BCD_W-1:0]  q_bcd,
   output logic              r_sign,
   output logic [BCD_W-1:0]  r_bcd
);

   logic [STATE_W-1:0] r_state, w_next_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [DATA_W-1:0]  r_q_mag, r_r_mag;
   logic [BCD_W-1:0]   r_q_acc, r_r_acc;
   logic               r_q_neg, r_r_neg;

   logic [DATA_W-1:0]  w_q_mag, w_r_mag;
   logic               w_q_neg, w_r_neg;
   logic [BCD_W-1:0]   w_q_step, w_r_step;
   logic               w_last_iter;

`ifdef SIGNED_BCD_SIGNED_EN
   // 8'h80 negates to itself, which read as unsigned is exactly 128.
   assign w_q_neg = quotient[DATA_W-1];
   assign w_r_neg = reminder[DATA_W-1];
   assign w_q_mag = w_q_neg ? (~quotient + 8'd1) : quotient;
   assign w_r_mag = w_r_neg ? (~reminder + 8'd1) : reminder;
`else
   assign w_q_neg = 1'b0;
   assign w_r_neg = 1'b0;
   assign w_q_mag = quotient;
   assign w_r_mag = reminder;
`endif

   bin2bcd_step u_q_step (
      .bcd_in  (r_q_acc),
      .bin_msb (r_q_mag[DATA_W-1]),
      .bcd_out (w_q_step)
   );

   bin2bcd_step u_r_step (
      .bcd_in  (r_r_acc),
      .bin_msb (r_r_mag[DATA_W-1]),
      .bcd_out (w_r_step)
   );

   assign w_last_iter = (r_cnt == CNT_W'(ITER_CNT - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   // Next state: every busy state except DONE stalls while start_sig is low,
   // so the done pulse is always exactly one cycle wide.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (start_sig) w_next_state = ST_LOAD;
         ST_LOAD:  if (start_sig) w_next_state = ST_SHIFT;
         ST_SHIFT: if (start_sig && w_last_iter) w_next_state = ST_OUT;
         ST_OUT:   if (start_sig) w_next_state = ST_DONE;
         ST_DONE:  w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      done_sig = (r_state == ST_DONE);
   end

   // Datapath: capture, shift and publish only on cycles the FSM advances.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_q_mag <= '0;
         r_r_mag <= '0;
         r_q_acc <= '0;
         r_r_acc <= '0;
         r_q_neg <= 1'b0;
         r_r_neg <= 1'b0;
         q_sign  <= 1'b0;
         q_bcd   <= '0;
         r_sign  <= 1'b0;
         r_bcd   <= '0;
      end else if (start_sig) begin
         case (r_state)
            ST_LOAD: begin
               r_q_mag <= w_q_mag;
               r_r_mag <= w_r_mag;
               r_q_neg <= w_q_neg;
               r_r_neg <= w_r_neg;
               r_q_acc <= '0;
               r_r_acc <= '0;
               r_cnt   <= '0;
            end
            ST_SHIFT: begin
               r_q_acc <= w_q_step;
               r_r_acc <= w_r_step;
               r_q_mag <= {r_q_mag[DATA_W-2:0], 1'b0};
               r_r_mag <= {r_r_mag[DATA_W-2:0], 1'b0};
               r_cnt   <= r_cnt + 3'd1;   // wraps 7 -> 0 on exit
            end
            ST_OUT: begin
               q_sign <= r_q_neg;
               q_bcd  <= r_q_acc;
               r_sign <= r_r_neg;
               r_bcd  <= r_r_acc;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/signed_bcd_module.md
SIGNED_BCD_MODULE -- requirements
Module: signed_bcd_module

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start_sig, input, 1, level request; conversion advances only while high.
REQ-004 SHALL have port quotient, input, 8, two's-complement quotient from the divider stage.
REQ-005 SHALL have port reminder, input, 8, two's-complement remainder from the divider stage.
REQ-006 SHALL have port done_sig, output, 1, one-cycle pulse when the result registers are valid.
REQ-007 SHALL have port q_sign, output, 1, quotient negative flag.
REQ-008 SHALL have port q_bcd, output, 12, quotient magnitude as hundreds/tens/units BCD, hundreds in [11:8].
REQ-009 SHALL have port r_sign, output, 1, remainder negative flag.
REQ-010 SHALL have port r_bcd, output, 12, remainder magnitude BCD, same digit order.

Function
REQ-011 SHALL implement states IDLE, LOAD, SHIFT, OUT, DONE, with IDLE as the reset state.
REQ-012 IDLE SHALL go to LOAD on a cycle with start_sig high.
REQ-013 LOAD SHALL capture both inputs, latch sign bits, and convert each to an 8-bit unsigned magnitude (negative: ~x+1); it SHALL clear the BCD accumulators.
REQ-014 SHALL treat 8'h80 as magnitude 128 (BCD 12'h128, sign 1); no overflow case exists.
REQ-015 SHALL run SHIFT for exactly 8 cycles, each doing one double-dabble step on both values in parallel: add 3 to any digit >= 5, then shift left one bit taking the magnitude MSB.
REQ-016 A 3-bit iteration counter SHALL count 0..7 in SHIFT and exit to OUT after count 7.
REQ-017 OUT SHALL load q_sign, q_bcd, r_sign, r_bcd from the accumulators in one cycle.
REQ-018 DONE SHALL assert done_sig for exactly one cycle, then return to IDLE.
REQ-019 Latency SHALL be fixed: with start_sig high from cycle 0 (IDLE), done_sig is high in cycle 11 and outputs change at the end of cycle 10.
REQ-020 If start_sig stays high after DONE, the next conversion SHALL begin with LOAD one cycle after IDLE, re-sampling the inputs.
REQ-021 While start_sig is low in any non-IDLE state, the state, counter and accumulators SHALL freeze; resuming continues from the frozen point.
REQ-022 Inputs SHALL be sampled only in LOAD; later changes SHALL NOT affect the current conversion.
REQ-023 Result outputs SHALL hold their last value until the next OUT state.
REQ-024 A zero magnitude SHALL give BCD 12'h000 with sign 0.

Reset
REQ-025 rst high SHALL, on the next clock edge, force IDLE, counter 0, accumulators 0, done_sig 0, q_sign 0, q_bcd 0, r_sign 0, r_bcd 0.
REQ-026 Reset SHALL take priority over start_sig and SHALL abort any conversion in progress without producing done_sig.

Configuration
REQ-027 Macro SIGNED_BCD_SIGNED_EN defined SHALL give signed interpretation as in REQ-013/014.
REQ-028 Without SIGNED_BCD_SIGNED_EN, inputs SHALL be unsigned 0..255, sign flags tied 0, and no negation logic built; range stays 0..255.

Structure
REQ-029 A shared package SHALL hold the state encoding constants, BCD width (12), data width (8) and iteration count (8).
REQ-030 One sub-module bin2bcd_step SHALL do the combinational add-3 and shift step for one value; it SHALL be instanced twice.

Verification
REQ-031 quotient=8'hFF, reminder=8'h03, start held -> cycle 11 done_sig=1; q_sign=1, q_bcd=12'h001, r_sign=0, r_bcd=12'h003.
REQ-032 quotient=8'h80, reminder=8'hFD -> q_sign=1, q_bcd=12'h128, r_sign=1, r_bcd=12'h003.
REQ-033 quotient=8'h7F, reminder=8'h00 -> q_bcd=12'h127, r_bcd=12'h000, both signs 0.
REQ-034 start_sig dropped for 5 cycles during SHIFT -> done_sig delayed exactly 5 cycles (cycle 16); result unchanged.
REQ-035 rst pulsed at cycle 6 of a conversion -> all outputs 0 next cycle, no done_sig; a fresh start then completes in 11 cycles.
REQ-036 Build without SIGNED_BCD_SIGNED_EN, quotient=8'hFF -> q_bcd=12'h255, q_sign=0.
